// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package instruction_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head is visible while non-empty.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited imem requests, in-order responses, buffered hand-off to decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] pend_count, ifq_count;
  logic [XLEN-1:0]  pend_head;
  logic             pend_full, pend_empty, ifq_full, ifq_empty;
  fetch_entry_t     ifq_din, ifq_head;
  logic [CNT_W:0]   used_credits;
  logic             req_fire, resp_keep, ifq_pop;
  logic             unused_flags;

  // Every in-flight request owns a buffer slot, so responses never need backpressure.
  assign used_credits   = {1'b0, pend_count} + {1'b0, ifq_count};
  assign imem_req_valid = !rst && !redirect_valid && (used_credits < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign ifq_din   = '{pc: pend_head, inst: imem_resp_data};
  assign ifq_pop   = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_target);
      // Everything still in flight is stale, except a response consumed this very cycle.
      drop_cnt_d = pend_count - CNT_W'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pend_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (imem_resp_valid),
    .clear (1'b0),
    .din   (fetch_pc_q),
    .dout  (pend_head),
    .count (pend_count),
    .full  (pend_full),
    .empty (pend_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_keep),
    .pop   (ifq_pop),
    .clear (redirect_valid),
    .din   (ifq_din),
    .dout  (ifq_head),
    .count (ifq_count),
    .full  (ifq_full),
    .empty (ifq_empty)
  );

  assign inst_valid = !ifq_empty;
  assign inst_data  = ifq_empty ? '0 : ifq_head.inst;
  assign inst_pc    = ifq_empty ? '0 : ifq_head.pc;

  assign unused_flags = ^{pend_full, pend_empty, ifq_full};

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model plus an in-order memory with variable latency.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { logic [31:0] pc; bit stale; } flight_t;

  mem_req_t     mem_q[$];
  flight_t      infl[$];
  fetch_entry_t buf_q[$];
  logic [31:0]  acc_log[$];
  logic [31:0]  pop_log[$];
  logic [31:0]  m_pc;
  int           cyc, last_due, mem_lat;
  int           checks, errors;
  bit           obs_inst_valid, obs_req_valid;
  logic [31:0]  obs_addr, obs_inst_pc, obs_inst_data;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ((addr ^ 32'h5A5A_0000) * 32'h0001_0003) + INST_NOP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    if (idx < q.size()) chk(tag, q[idx], exp);
    else chk({tag, "_count"}, q.size(), idx + 1);
  endtask

  function automatic bit model_req();
    return !rst && !redirect_valid && ((infl.size() + buf_q.size()) < DEPTH);
  endfunction

  task automatic model_check();
    bit exp_req;
    exp_req = model_req();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, buf_q.size() != 0});
    if (buf_q.size() != 0) begin
      chk("inst_pc", inst_pc, buf_q[0].pc);
      chk("inst_data", inst_data, buf_q[0].inst);
    end
  endtask

  task automatic model_update(input bit acc);
    bit      do_pop;
    flight_t f;
    do_pop = (buf_q.size() != 0) && inst_ready;
    if (redirect_valid) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      if (imem_resp_valid && infl.size() != 0) void'(infl.pop_front());
      buf_q.delete();
      m_pc = redirect_target & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) void'(buf_q.pop_front());
      if (imem_resp_valid && infl.size() != 0) begin
        f = infl.pop_front();
        if (!f.stale) buf_q.push_back('{pc: f.pc, inst: mem_word(f.pc)});
      end
      if (acc) begin
        infl.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: inputs are already set at the falling edge; memory answers, then check.
  task automatic tick();
    int due;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    model_check();
    obs_req_valid  = imem_req_valid;
    obs_addr       = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst_pc    = inst_pc;
    obs_inst_data  = inst_data;
    if (inst_valid && inst_ready && !redirect_valid) pop_log.push_back(inst_pc);
    if (imem_resp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      acc_log.push_back(imem_req_addr);
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{addr: imem_req_addr, due: due});
      last_due = due;
    end
    model_update(model_req() && imem_req_ready);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    infl.delete();
    buf_q.delete();
    mem_q.delete();
    m_pc     = RST_PC;
    last_due = cyc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
  endtask

  initial begin
    int  first;
    bit  hit;
    checks = 0; errors = 0; cyc = 0; last_due = 0; mem_lat = 1;
    imem_req_ready  = 1'b1;
    imem_resp_data  = '0;
    inst_ready      = 1'b1;
    redirect_target = '0;
    do_reset();

    // Streaming with a 1-cycle memory and an always-ready decoder.
    acc_log.delete(); pop_log.delete();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_inst_valid && first < 0) first = i;
    end
    chk("first_valid_cycle", first, 2);
    chk_log("stream_req", acc_log, 0, 32'h0);
    chk_log("stream_req", acc_log, 1, 32'h4);
    chk_log("stream_req", acc_log, 2, 32'h8);
    chk_log("stream_pc", pop_log, 0, 32'h0);
    chk_log("stream_pc", pop_log, 1, 32'h4);
    chk_log("stream_pc", pop_log, 2, 32'h8);

    // Decode stall: credits cap the requests at the buffer depth.
    do_reset();
    acc_log.delete(); pop_log.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_req_count", acc_log.size(), DEPTH);
    chk("stall_req_valid", {31'b0, obs_req_valid}, 32'd0);
    chk("stall_held_pc", obs_inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_log("stall_pc", pop_log, 0, 32'h0);
    chk_log("stall_pc", pop_log, 1, 32'h4);
    chk_log("stall_pc", pop_log, 2, 32'h8);

    // Redirect with two slow requests in flight.
    do_reset();
    acc_log.delete();
    mem_lat = 3;
    tick(); tick();
    chk("redir_outstanding", acc_log.size(), 2);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("redir_fifo_empty", {31'b0, obs_inst_valid}, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      hit = obs_inst_valid;
    end
    chk("redir_seen", {31'b0, hit}, 32'd1);
    chk("redir_pc", obs_inst_pc, 32'h0000_0100);
    chk("redir_data", obs_inst_data, mem_word(32'h0000_0100));

    // Misaligned target is forced to a word boundary.
    mem_lat = 1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("align_addr", obs_addr, 32'h0000_0200);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      hit = obs_inst_valid;
    end
    chk("align_pc", obs_inst_pc, 32'h0000_0200);

    // Redirect coinciding with a response and an instruction pop.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mem_q.size() != 0 && mem_q[0].due <= cyc && buf_q.size() != 0) hit = 1'b1;
      else tick();
    end
    chk("collide_setup", {31'b0, hit}, 32'd1);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("collide_no_valid", {31'b0, obs_inst_valid}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Address wrap at the top of memory, then reset mid-stream.
    acc_log.delete();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_log("wrap_req", acc_log, 0, 32'hFFFF_FFFC);
    chk_log("wrap_req", acc_log, 1, 32'h0000_0000);
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 6; i++) tick();
    chk_log("restart_req", acc_log, 0, RST_PC);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      imem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_lat         = $urandom_range(1, 4);
      inst_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      if (i == 400) do_reset();
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage directly upstream of the core's decode/regfile/ALU path.
- Owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, accepts in-order responses, and buffers fetched instructions.
- Presents each buffered instruction with its PC to decode over a valid/ready channel.
- Accepts a redirect (branch/jump target) that flushes all younger work.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response data valid (in order, >=1 cycle after accept, no backpressure)
imem_resp_data  in  32  instruction word
redirect_valid  in  1  flush and restart fetch
redirect_target  in  32  new fetch address
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst_data  out  32  instruction word
inst_pc  out  32  PC of inst_data

Behaviour:
- Reset (async assert, sync-safe deassert) sets the following.
  - fetch_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- Credit rule: imem_req_valid=1 iff !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH. This guarantees every response has a FIFO slot.
- imem_req_addr=fetch_pc. On valid&&ready: fetch_pc+=4 with 32-bit wrap; outstanding+1; fetch_pc pushed into a pending-PC queue of depth FIFO_DEPTH.
- Response with drop_cnt==0: push {pending-PC head, imem_resp_data} into FIFO, pop pending queue, outstanding-1.
- Response with drop_cnt>0: discard data, pop pending queue, drop_cnt-1, outstanding-1.
- Same-cycle request accept and response: outstanding unchanged.
- inst_valid = FIFO non-empty. inst_data/inst_pc = FIFO head. Pop on inst_valid&&inst_ready. FIFO is first-word fall-through, so latency is resp -> inst_valid the next cycle.
- Same-cycle push and pop on a full FIFO is legal only when a pop occurs. The credit rule prevents overflow.
- Redirect (priority over everything in that cycle):
  - fetch_pc <= {redirect_target[31:2],2'b00}; low bits are silently forced to zero.
  - FIFO cleared; any inst pop that cycle is ignored. Decode must not treat the output as consumed: inst_valid is already killed by the redirect source.
  - drop_cnt <= outstanding − (imem_resp_valid ? 1 : 0) + (current drop_cnt adjustments). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. Fetch resumes from the target the next cycle, subject to credits.
- Back-to-back redirects: the last one wins; drop_cnt recomputed each time from outstanding.
- Stall: inst_ready=0 holds inst_data/inst_pc stable. Requests stop once credits are exhausted.
- Reset mid-transaction: all counters clear. Memory is reset by the same rst, so no stale responses arrive.

Decomposition:
- Shared package constants:
  - XLEN=32
  - INST_BYTES=4
  - INST_NOP=32'h0000_0013 (addi x0,x0,0, for bench and downstream bubbles)
  - fetch entry typedef {pc[31:0], inst[31:0]}
- One sub-module, fetch_fifo: synchronous FWFT FIFO parameterised by DEPTH and WIDTH, with push/pop/clear, count, full, empty.
  - Instantiated twice: instruction buffer (WIDTH=64) and pending-PC queue (WIDTH=32).

Test Plan:
- Reset, memory always ready, 1-cycle latency, inst_ready=1 -> requests at 0x0,0x4,0x8; inst_pc sequence 0x0,0x4,0x8 with matching words; first inst_valid 2 cycles after reset release.
- inst_ready=0 for 10 cycles after first response -> exactly FIFO_DEPTH (2) requests issued, then imem_req_valid=0; inst_pc held at 0x0; on release pcs 0x0,0x4,0x8 in order, no loss or duplicate.
- Redirect to 0x100 while 2 requests outstanding (3-cycle latency) -> both stale responses dropped; next inst_pc=0x100 with data from 0x100; FIFO empty in the cycle after redirect.
- Redirect target 0x0000_0203 -> imem_req_addr=0x0000_0200, inst_pc=0x200.
- Redirect in the same cycle as a response and an inst pop -> response discarded, drop_cnt = remaining outstanding, no spurious inst_valid next cycle.
- Redirect to 0xFFFF_FFFC -> requests at 0xFFFF_FFFC then 0x0000_0000 (wrap); rst asserted mid-stream -> all outputs zero immediately, fetch restarts at RESET_PC.
